// File: rtl/led_blink_ctrl_pkg.sv
// Shared definitions for the LED blink controller: mode encodings, blank polarity
// and the mode-sequencing helpers used by the top level.
package led_blink_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_SHOW  = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_OFF   = 2'd2,
        MODE_FAST  = 2'd3
    } mode_e;

    // Polarity of the decoder select input, shared with the display decoder.
    localparam logic BLANK_ON  = 1'b1;
    localparam logic BLANK_OFF = 1'b0;

    // Mode following m on an accepted press; FAST only exists in the fast-blink build.
    function automatic mode_e next_mode(input mode_e m, input bit fast_en);
        mode_e n;
        case (m)
            MODE_SHOW:  n = MODE_BLINK;
            MODE_BLINK: n = fast_en ? MODE_FAST : MODE_OFF;
            MODE_OFF:   n = MODE_SHOW;
            MODE_FAST:  n = fast_en ? MODE_OFF : MODE_SHOW;
            default:    n = MODE_SHOW;
        endcase
        return n;
    endfunction

    // Fast half-period is a quarter of the slow one, never below one cycle.
    function automatic logic [15:0] fast_half(input logic [15:0] hp);
        return ((hp >> 2) == 16'd0) ? 16'd1 : (hp >> 2);
    endfunction

endpackage

// File: rtl/led_blink_ctrl_debounce.sv
// Push-button front end: 2-FF synchroniser, stability counter and registered
// rising-edge detect of the debounced level.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter int          CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db,
    output logic rise
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;
    logic             db_prev_q;
    logic             rise_q;

    // NOTE: the synchroniser flops are reset as well so the first post-reset
    // comparison against db_q never sees X; non-blocking assignments keep every
    // flop in this block sampling the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            if (sync_q[1] != db_q) begin
                if (cnt_q == DB_LAST) begin
                    db_q  <= sync_q[1];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end else begin
                cnt_q <= '0;
            end
            // Edge is taken one stage after acceptance so the pulse is fully registered.
            db_prev_q <= db_q;
            rise_q    <= db_q & ~db_prev_q;
        end
    end

    assign btn_db = db_q;
    assign rise   = rise_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Display-mode controller feeding the LED decoder select: SHOW / BLINK / OFF stepped by
// debounced presses. Define LED_FAST_BLINK_EN to add the FAST blink mode after BLINK.
module led_blink_ctrl
    import led_blink_ctrl_pkg::*;
#(
    parameter logic [15:0] HALF_PERIOD     = 16'd25000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter int          CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       en,
    output logic       blank,
    output logic [1:0] mode,
    output logic       press
);

`ifdef LED_FAST_BLINK_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(HALF_PERIOD - 16'd1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(fast_half(HALF_PERIOD) - 16'd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic btn_db;
    logic rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn),
        .btn_db (btn_db),
        .rise   (rise)
    );

    // The debounced level is only needed by the edge detect inside the debouncer.
    logic unused_btn_db;
    assign unused_btn_db = btn_db;

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgl_q, tgl_d;
    logic             blank_q, blank_d;

    logic             blinking;
    logic             illegal;
    logic [CNT_W-1:0] cnt_last;

    assign blinking = (mode_q == MODE_BLINK) || (FAST_EN && (mode_q == MODE_FAST));
    assign illegal  = !FAST_EN && (mode_q == MODE_FAST);
    assign cnt_last = (mode_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;

    // NOTE: every _d gets a default first so no path through this block infers a latch.
    always_comb begin
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        tgl_d   = tgl_q;
        blank_d = BLANK_ON;

        if (en) begin
            // blank follows the state held before this edge, so it lags a mode change by one cycle.
            case (mode_q)
                MODE_SHOW:  blank_d = BLANK_OFF;
                MODE_OFF:   blank_d = BLANK_ON;
                MODE_BLINK: blank_d = tgl_q ? BLANK_ON : BLANK_OFF;
                MODE_FAST:  blank_d = (FAST_EN && tgl_q) ? BLANK_ON : BLANK_OFF;
                default:    blank_d = BLANK_OFF;
            endcase

            if (illegal) begin
                mode_d = MODE_SHOW;
                cnt_d  = '0;
                tgl_d  = 1'b0;
            end else if (rise) begin
                // A press on the wrap cycle wins: new state, cleared counter, no toggle.
                mode_d = next_mode(mode_q, FAST_EN);
                cnt_d  = '0;
                tgl_d  = 1'b0;
            end else if (blinking) begin
                if (cnt_q == cnt_last) begin
                    cnt_d = '0;
                    tgl_d = ~tgl_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_SHOW;
            cnt_q   <= '0;
            tgl_q   <= 1'b0;
            blank_q <= BLANK_OFF;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            tgl_q   <= tgl_d;
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
    assign mode  = mode_q;
    assign press = rise;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl (HALF_PERIOD=4, DEBOUNCE_CYCLES=3, CNT_W=4):
// directed literal checks plus randomized traffic compared against a behavioural model.
module tb_led_blink_ctrl;

    localparam logic [15:0] HP    = 16'd4;
    localparam logic [15:0] DEB   = 16'd3;
    localparam int          CW    = 4;
    localparam int          HPI   = 4;
    localparam int          HPF   = 1;
    localparam int          DEBI  = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn   = 1'b0;
    logic       en    = 1'b0;
    logic       blank;
    logic [1:0] mode;
    logic       press;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    led_blink_ctrl #(
        .HALF_PERIOD     (HP),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .en    (en),
        .blank (blank),
        .mode  (mode),
        .press (press)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // btn history per clock; debounced level flips once DEBOUNCE_CYCLES consecutive
    // synchronised samples (btn two clocks ago and earlier) all differ from it.
    bit hist[$];
    bit m_db, m_db_prev, m_press, m_blank;
    int m_mode, m_n;
    bit m_all_diff, m_new_press;

    function automatic bit sample_ago(input int j);
        if (j <= hist.size()) return hist[hist.size() - j];
        return 1'b0;
    endfunction

    function automatic int model_next(input int m);
`ifdef LED_FAST_BLINK_EN
        case (m)
            0: return 1;
            1: return 3;
            3: return 2;
            default: return 0;
        endcase
`else
        case (m)
            0: return 1;
            1: return 2;
            default: return 0;
        endcase
`endif
    endfunction

    // n = enabled clocks spent in a blink mode since entry; phase flips every half-period.
    function automatic bit blink_phase(input int m, input int n);
        int half;
        half = (m == 3) ? HPF : HPI;
        return ((n / half) % 2) == 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_db = 0; m_db_prev = 0; m_press = 0; m_blank = 0;
            m_mode = 0; m_n = 0;
        end else begin
            if (!en) m_blank = 1'b1;
            else if (m_mode == 0) m_blank = 1'b0;
            else if (m_mode == 2) m_blank = 1'b1;
            else m_blank = blink_phase(m_mode, m_n);

            if (en && m_press) begin
                m_mode = model_next(m_mode);
                m_n    = 0;
            end else if (en && (m_mode == 1 || m_mode == 3)) begin
                m_n++;
            end

            m_new_press = m_db && !m_db_prev;
            m_all_diff  = 1'b1;
            for (int k = 0; k < DEBI; k++)
                if (sample_ago(2 + k) == m_db) m_all_diff = 1'b0;
            m_db_prev = m_db;
            if (m_all_diff) m_db = !m_db;
            m_press = m_new_press;

            hist.push_back(btn);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp_blank", blank, m_blank);
            check("cmp_mode",  mode,  m_mode);
            check("cmp_press", press, m_press);
        end
    end

    // ---------------- directed helpers ----------------
    // Holds btn until a press pulse is seen (bounded), then releases at the next negedge.
    task automatic do_press();
        bit found;
        found = 1'b0;
        @(negedge clk) btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (press) begin
                found = 1'b1;
                break;
            end
        end
        check("press_seen", found, 1);
        @(negedge clk) btn = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, actual=running required=done");
        $fatal(1);
    end

    initial begin
        int  n_press, first_press;
        bit  pat [4];
        bit  exp_b;
        int  hold;

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_mode", mode, 0);
        check("rst_blank", blank, 0);
        check("rst_press", press, 0);
        cmp_on = 1'b1;
        @(negedge clk) begin rst_n = 1'b1; en = 1'b1; end
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_mode", mode, 0);
        check("post_rst_blank", blank, 0);

        // 2 + 4: clean press held 10 cycles; press on edge 6, BLINK from edge 7
        n_press = 0; first_press = 0;
        @(negedge clk) btn = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            @(posedge clk); #1;
            if (press) begin
                n_press++;
                if (first_press == 0) first_press = e;
            end
            check("clean_mode", mode, (e >= 7) ? 1 : 0);
            exp_b = ((e >= 12) && (e <= 15)) || (e >= 20);
            check("blink_pattern", blank, exp_b);
            if (e == 10) @(negedge clk) btn = 1'b0;
        end
        check("press_latency", first_press, 6);
        check("press_count", n_press, 1);

        // 3: bounce shorter than the debounce window
        pat = '{1'b1, 1'b0, 1'b1, 1'b0};
        n_press = 0;
        for (int i = 0; i < 4; i++) @(negedge clk) btn = pat[i];
        @(negedge clk) btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (press) n_press++;
        end
        check("bounce_press", n_press, 0);
        check("bounce_mode", mode, 1);

        // 4: BLINK -> OFF
        do_press();
        settle(8);
        check("off_mode", mode, 2);
        check("off_blank", blank, 1);

        // 5: en=0 with the blink counter at 2
        do_press();
        settle(8);
        check("show_mode", mode, 0);
        do_press();
        repeat (3) @(posedge clk);
        @(negedge clk) en = 1'b0;
        @(posedge clk); #1;
        check("en_off_blank", blank, 1);
        settle(6);
        do_press();
        settle(8);
        check("en_off_mode_hold", mode, 1);
        check("en_off_blank_hold", blank, 1);
        @(negedge clk) en = 1'b1;
        @(posedge clk); #1;
        check("resume_q0", blank, 0);
        @(posedge clk); #1;
        check("resume_q1", blank, 0);
        @(posedge clk); #1;
        check("resume_q2", blank, 1);
        check("resume_mode", mode, 1);

        // 6: async reset mid half-period
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_blank", blank, 0);
        check("async_rst_mode", mode, 0);
        check("async_rst_press", press, 0);
        settle(2);
        rst_n = 1'b1;
        settle(2);

        // 7: fast blink (or plain 3-state wrap in the default build)
`ifdef LED_FAST_BLINK_EN
        do_press();
        settle(8);
        do_press();
        @(posedge clk); #1;
        check("fast_mode", mode, 3);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            check("fast_toggle", blank, j % 2);
        end
        settle(6);
        do_press();
        settle(8);
        check("fast_to_off", mode, 2);
        check("fast_off_blank", blank, 1);
`else
        do_press();
        settle(8);
        do_press();
        settle(8);
        check("wrap_off", mode, 2);
        do_press();
        settle(8);
        check("wrap_show", mode, 0);
        check("wrap_show_blank", blank, 0);
`endif

        // randomized traffic against the model
        for (int it = 0; it < 2000; it++) begin
            @(negedge clk);
            btn  = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 9) != 0);
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk) rst_n = 1'b1;
            end
            settle(hold);
        end

        settle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
